// File: rtl/mem_responder.sv
// Memory-side responder: serves read/write bursts from an internal word array.
// Optional MEM_RESPONDER_BOUNDS_CHECK_EN: out-of-range beats read 0 / drop writes and set err.
module mem_responder #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 32,
    parameter int MEM_DATA_BITS = 64,
    parameter int DEPTH_BITS    = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    input  logic                     mem_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  mem_req_len,
    input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    input  logic                     mem_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_wr_bits,
    output logic                     mem_rd_valid,
    output logic [MEM_DATA_BITS-1:0] mem_rd_bits,
    input  logic                     mem_rd_ready,
    output logic                     busy,
    output logic                     err
);

    localparam int OFF_BITS = $clog2(MEM_DATA_BITS / 8);
    localparam int DEPTH    = 2 ** DEPTH_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_t;

    state_t                    state_q, state_d;
    logic [DEPTH_BITS-1:0]     ptr_q, ptr_d;
    logic [MEM_LEN_BITS-1:0]   remaining_q, remaining_d;
    logic                      err_q, err_d;
    logic                      oob_q, oob_d;
    logic                      advance;
    logic                      wr_fire;
    logic [DEPTH_BITS-1:0]     req_ptr;
    logic [MEM_DATA_BITS-1:0]  mem_q [DEPTH];

    assign req_ptr = DEPTH_BITS'(mem_req_addr >> OFF_BITS);

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    logic [MEM_ADDR_BITS-1:0] req_idx;
    logic                     req_hi_nz;
    logic                     req_over;

    assign req_idx   = mem_req_addr >> OFF_BITS;
    assign req_hi_nz = (req_idx >> DEPTH_BITS) != '0;
    assign req_over  = ({1'b0, req_idx} + (MEM_ADDR_BITS + 1)'(mem_req_len))
                       > (MEM_ADDR_BITS + 1)'(DEPTH - 1);
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        oob_d       = oob_q;
        advance     = 1'b0;
        wr_fire     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_wr_valid) err_d = 1'b1;
                if (mem_req_valid) begin
                    ptr_d       = req_ptr;
                    remaining_d = mem_req_len;
                    state_d     = mem_req_opcode ? S_WRITE : S_READ;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
                    oob_d = req_hi_nz;
                    if (req_over) err_d = 1'b1;
`else
                    oob_d = 1'b0;
`endif
                end
            end
            S_READ: begin
                advance = mem_rd_ready;
                if (mem_req_valid || mem_wr_valid) err_d = 1'b1;
            end
            S_WRITE: begin
                advance = mem_wr_valid;
                wr_fire = mem_wr_valid && !oob_q;
                if (mem_req_valid) err_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // oob marks beats past the last word; once set it holds for the rest of the burst
        if (advance) begin
            if (remaining_q == '0) begin
                state_d = S_IDLE;
            end else begin
                remaining_d = remaining_q - 1'b1;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
                if (ptr_q == '1) oob_d = 1'b1;
                else             ptr_d = ptr_q + 1'b1;
`else
                ptr_d = ptr_q + 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
            oob_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
            oob_q       <= oob_d;
        end
    end

    // Storage is deliberately not reset; partially written bursts survive a reset.
    always_ff @(posedge clock) begin
        if (wr_fire) mem_q[ptr_q] <= mem_wr_bits;
    end

    assign mem_rd_valid = (state_q == S_READ);
    assign mem_rd_bits  = (mem_rd_valid && !oob_q) ? mem_q[ptr_q] : '0;
    assign busy         = (state_q != S_IDLE);
    assign err          = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: queue-based burst model plus directed literal checks.
module tb_mem_responder;

    localparam int NW = 1024;

    logic        clock;
    logic        reset;
    logic        mem_req_valid;
    logic        mem_req_opcode;
    logic [7:0]  mem_req_len;
    logic [31:0] mem_req_addr;
    logic        mem_wr_valid;
    logic [63:0] mem_wr_bits;
    logic        mem_rd_valid;
    logic [63:0] mem_rd_bits;
    logic        mem_rd_ready;
    logic        busy;
    logic        err;

    mem_responder #(
        .MEM_LEN_BITS (8),
        .MEM_ADDR_BITS(32),
        .MEM_DATA_BITS(64),
        .DEPTH_BITS   (10)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_req_valid (mem_req_valid),
        .mem_req_opcode(mem_req_opcode),
        .mem_req_len   (mem_req_len),
        .mem_req_addr  (mem_req_addr),
        .mem_wr_valid  (mem_wr_valid),
        .mem_wr_bits   (mem_wr_bits),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_bits   (mem_rd_bits),
        .mem_rd_ready  (mem_rd_ready),
        .busy          (busy),
        .err           (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst is the list of word indices it will touch (-1 = beyond array).
    logic [63:0] mmem  [NW];
    bit          known [NW];
    bit          m_busy, m_read, m_err;
    int          words[$];
    longint      m_idx;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy = 0;
            m_read = 0;
            m_err  = 0;
            words.delete();
        end else if (!m_busy) begin
            if (mem_wr_valid) m_err = 1;
            if (mem_req_valid) begin
                m_idx = longint'(mem_req_addr >> 3);
                words.delete();
                for (int b = 0; b <= int'(mem_req_len); b++) begin
                    longint w;
                    w = m_idx + b;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
                    words.push_back(w > NW - 1 ? -1 : int'(w));
`else
                    words.push_back(int'(w % NW));
`endif
                end
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
                if (m_idx + longint'(mem_req_len) > NW - 1) m_err = 1;
`endif
                m_busy = 1;
                m_read = !mem_req_opcode;
            end
        end else begin
            if (mem_req_valid) m_err = 1;
            if (m_read) begin
                if (mem_wr_valid) m_err = 1;
                if (mem_rd_ready) void'(words.pop_front());
            end else if (mem_wr_valid) begin
                int w;
                w = words.pop_front();
                if (w >= 0) begin
                    mmem[w]  = mem_wr_bits;
                    known[w] = 1;
                end
            end
            if (words.size() == 0) m_busy = 0;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_rd_valid", {63'd0, mem_rd_valid}, 64'd0);
            chk("rst_rd_bits", mem_rd_bits, 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_err", {63'd0, err}, 64'd0);
        end else begin
            chk("busy", {63'd0, busy}, {63'd0, m_busy});
            chk("err", {63'd0, err}, {63'd0, m_err});
            chk("rd_valid", {63'd0, mem_rd_valid}, {63'd0, m_busy && m_read});
            if (m_busy && m_read) begin
                int w;
                w = words[0];
                if (w < 0) chk("rd_bits_oob", mem_rd_bits, 64'd0);
                else if (known[w]) chk("rd_bits", mem_rd_bits, mmem[w]);
            end
        end
    end

    logic [63:0] wd[$];
    logic [63:0] got[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_req(input bit op, input int len, input logic [31:0] addr);
        mem_req_valid  = 1'b1;
        mem_req_opcode = op;
        mem_req_len    = 8'(len);
        mem_req_addr   = addr;
        tick();
        mem_req_valid  = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input int len);
        send_req(1'b1, len, addr);
        for (int i = 0; i <= len; i++) begin
            mem_wr_valid = 1'b1;
            mem_wr_bits  = wd[i];
            tick();
        end
        mem_wr_valid = 1'b0;
    endtask

    task automatic read_burst(input logic [31:0] addr, input int len);
        send_req(1'b0, len, addr);
        mem_rd_ready = 1'b1;
        got.delete();
        for (int i = 0; i <= len; i++) begin
            @(negedge clock);
            chk("rd_valid_beat", {63'd0, mem_rd_valid}, 64'd1);
            got.push_back(mem_rd_bits);
            tick();
        end
        mem_rd_ready = 1'b0;
    endtask

    task automatic rand_burst(input bit strays);
        bit          op;
        int          len, idx, r, n;
        logic [31:0] addr;
        op  = 1'($urandom_range(0, 1));
        len = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
        r   = int'($urandom_range(0, 9));
        if (r < 6)      idx = int'($urandom_range(0, NW - 1));
        else if (r < 9) idx = int'($urandom_range(NW - 8, NW - 1));
        else            idx = int'($urandom_range(NW, 5000));
        addr = (32'(idx) << 3) | 32'($urandom_range(0, 7));
        send_req(op, len, addr);
        n = 0;
        while (m_busy && n < 2000) begin
            if (!op) mem_rd_ready = ($urandom_range(0, 3) != 0);
            else begin
                mem_wr_valid = ($urandom_range(0, 3) != 0);
                mem_wr_bits  = {$urandom, $urandom};
            end
            if (strays && $urandom_range(0, 15) == 0) begin
                mem_req_valid  = 1'b1;
                mem_req_opcode = 1'($urandom_range(0, 1));
                mem_req_len    = 8'($urandom_range(0, 255));
                mem_req_addr   = $urandom;
            end
            if (strays && !op && $urandom_range(0, 15) == 0) mem_wr_valid = 1'b1;
            tick();
            mem_req_valid = 1'b0;
            if (!op) mem_wr_valid = 1'b0;
            n++;
        end
        mem_rd_ready = 1'b0;
        mem_wr_valid = 1'b0;
        if (n >= 2000) begin
            n_assert++;
            n_fail++;
            $display("FAIL burst_timeout: got busy after %0d cycles, expected idle", n);
        end
        if (strays && $urandom_range(0, 7) == 0) begin
            mem_wr_valid = 1'b1;
            tick();
            mem_wr_valid = 1'b0;
        end
        if ($urandom_range(0, 1) == 1) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        mem_req_valid = 1'b0; mem_req_opcode = 1'b0; mem_req_len = '0; mem_req_addr = '0;
        mem_wr_valid = 1'b0; mem_wr_bits = '0; mem_rd_ready = 1'b0;
        repeat (3) tick();
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_err", {63'd0, err}, 64'd0);
        reset = 1'b1;
        tick();

        // write then read
        wd = '{64'h11, 64'h22, 64'h33, 64'h44};
        write_burst(32'h40, 3);
        read_burst(32'h40, 3);
        for (int i = 0; i < 4; i++) chk("wr_rd_data", got[i], 64'h11 * 64'(i + 1));
        @(negedge clock);
        chk("wr_rd_busy_end", {63'd0, busy}, 64'd0);

        // backpressure
        wd = '{64'hA5, 64'h5A};
        write_burst(32'h200, 1);
        send_req(1'b0, 1, 32'h200);
        repeat (5) begin
            @(negedge clock);
            chk("bp_valid", {63'd0, mem_rd_valid}, 64'd1);
            chk("bp_bits", mem_rd_bits, 64'hA5);
        end
        mem_rd_ready = 1'b1;
        tick();
        @(negedge clock);
        chk("bp_second", mem_rd_bits, 64'h5A);
        tick();
        mem_rd_ready = 1'b0;
        @(negedge clock);
        chk("bp_busy_end", {63'd0, busy}, 64'd0);

        // single beat then back-to-back request
        wd = '{64'h77};
        write_burst(32'h300, 0);
        send_req(1'b0, 0, 32'h300);
        mem_rd_ready = 1'b1;
        @(negedge clock);
        chk("single_bits", mem_rd_bits, 64'h77);
        tick();
        send_req(1'b0, 0, 32'h40);
        @(negedge clock);
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        chk("b2b_err", {63'd0, err}, 64'd0);
        chk("b2b_bits", mem_rd_bits, 64'h11);
        tick();
        mem_rd_ready = 1'b0;

        // wrap / bounds at the top of the array
        wd = '{64'h1234};
        write_burst(32'h0, 0);
        wd = '{64'hDEAD, 64'hBEEF};
        write_burst(32'(1023) << 3, 1);
        read_burst(32'(1023) << 3, 0);
        chk("wrap_top", got[0], 64'hDEAD);
        read_burst(32'h0, 0);
        @(negedge clock);
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        chk("bounds_word0", got[0], 64'h1234);
        chk("bounds_err", {63'd0, err}, 64'd1);
`else
        chk("wrap_word0", got[0], 64'hBEEF);
        chk("wrap_err", {63'd0, err}, 64'd0);
`endif

        // maximum length burst: 256 beats
        wd.delete();
        for (int i = 0; i < 256; i++) wd.push_back(64'(i * 3 + 1));
        write_burst(32'h0, 255);
        read_burst(32'h0, 255);
        for (int i = 0; i < 256; i++) chk("len255_data", got[i], 64'(i * 3 + 1));
        @(negedge clock);
        chk("len255_busy_end", {63'd0, busy}, 64'd0);

        repeat (60) rand_burst(1'b0);

        // collision during a len-7 read
        wd.delete();
        for (int i = 0; i < 8; i++) wd.push_back({$urandom, $urandom});
        write_burst(32'h1000, 7);
        send_req(1'b0, 7, 32'h1000);
        mem_rd_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            got.push_back(mem_rd_bits);
            if (i == 3) begin
                mem_req_valid = 1'b1; mem_req_opcode = 1'b1; mem_req_len = 8'd0; mem_req_addr = 32'h0;
            end
            tick();
            mem_req_valid = 1'b0;
        end
        mem_rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) chk("coll_data", got[i], wd[i]);
        @(negedge clock);
        chk("coll_err", {63'd0, err}, 64'd1);
        chk("coll_busy_end", {63'd0, busy}, 64'd0);
        repeat (5) tick();
        chk("coll_err_sticky", {63'd0, err}, 64'd1);

        repeat (40) rand_burst(1'b1);

        // reset mid-write keeps written words; reset mid-read aborts at once
        send_req(1'b1, 3, 32'h1800);
        mem_wr_valid = 1'b1; mem_wr_bits = 64'hC1; tick();
        mem_wr_bits = 64'hC2; tick();
        mem_wr_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rstw_busy", {63'd0, busy}, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        read_burst(32'h1800, 1);
        chk("rstw_kept0", got[0], 64'hC1);
        chk("rstw_kept1", got[1], 64'hC2);

        send_req(1'b0, 7, 32'h1000);
        mem_rd_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rstr_rd_valid", {63'd0, mem_rd_valid}, 64'd0);
        chk("rstr_rd_bits", mem_rd_bits, 64'd0);
        chk("rstr_busy", {63'd0, busy}, 64'd0);
        chk("rstr_err", {63'd0, err}, 64'd0);
        tick(); tick();
        mem_rd_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        chk("post_rst_err", {63'd0, err}, 64'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the accelerator memory request interface. It sits where the host memory model normally sits and serves the accelerator's read and write bursts from an internal word-addressed array. This allows stand-alone simulation and on-chip scratchpad use without the host DPI. It decodes each request, streams read beats under ready backpressure, and absorbs write beats into storage.

## Interface
- `MEM_LEN_BITS`, 8, burst length field width; a burst is `len+1` beats
- `MEM_ADDR_BITS`, 32, byte address width
- `MEM_DATA_BITS`, 64, beat width; must be a power of two and at least 8
- `DEPTH_BITS`, 10, log2 of the number of array words
- `clock`  in  1  single clock for the block
- `reset`  in  1  asynchronous, active-low reset; 0 = in reset
- `mem_req_valid`  in  1  request strobe, one cycle per request
- `mem_req_opcode`  in  1  0 = read, 1 = write
- `mem_req_len`  in  MEM_LEN_BITS  beat count minus one
- `mem_req_addr`  in  MEM_ADDR_BITS  byte address of the first beat
- `mem_wr_valid`  in  1  write beat strobe
- `mem_wr_bits`  in  MEM_DATA_BITS  write beat data
- `mem_rd_valid`  out  1  read beat valid
- `mem_rd_bits`  out  MEM_DATA_BITS  read beat data
- `mem_rd_ready`  in  1  initiator accepts the read beat
- `busy`  out  1  burst in progress
- `err`  out  1  sticky error flag; cleared only by reset

## Operation
- Word index = `mem_req_addr >> log2(MEM_DATA_BITS/8)`. The low byte-offset bits are ignored.
- The FSM has three states: IDLE, READ and WRITE.
- In IDLE, a cycle with `mem_req_valid` captures the word index into `ptr`, captures `len` into `remaining`, and moves to READ or WRITE according to `mem_req_opcode`.
- READ:
  - `mem_rd_valid` = 1 and `mem_rd_bits` = `array[ptr]`, driven combinationally from `ptr`.
  - On `mem_rd_valid && mem_rd_ready`:
    - If `remaining` == 0, return to IDLE.
    - Otherwise `ptr` += 1 and `remaining` -= 1.
  - Without ready, `mem_rd_valid` and `mem_rd_bits` hold stable.
- WRITE:
  - Each cycle with `mem_wr_valid` writes `array[ptr]` = `mem_wr_bits`.
  - After each write beat, `ptr` and `remaining` advance exactly as in READ.
  - After the beat with `remaining` == 0, return to IDLE.
  - There is no write backpressure.
- `ptr` wraps modulo 2^DEPTH_BITS, subject to Configuration.
- A request that arrives while not IDLE is dropped, does not disturb the active burst, and sets `err`.
- `mem_wr_valid` while in IDLE or READ is ignored and sets `err`.
- `mem_rd_ready` outside READ is ignored.
- The array is not cleared by reset. Contents are undefined until written.

## Timing
- Values while reset is low:
  - `mem_rd_valid` = 0, `mem_rd_bits` = 0, `busy` = 0, `err` = 0.
  - FSM = IDLE, `ptr` = 0, `remaining` = 0.
- Reset asserted mid-burst aborts the burst immediately. Any partially written words are kept.
- Request sampled in cycle T:
  - `busy` = 1 and the new state take effect from T+1.
  - For a read, the first `mem_rd_valid` appears in T+1, giving 1-cycle read latency.
  - For a write, the first beat is accepted in T+1. `mem_wr_valid` in cycle T is not part of the burst and sets `err`.
- Read throughput is one beat per cycle while `mem_rd_ready` stays high. A `len+1`-beat read with ready held high completes its last handshake in T+len+1.
- On the last handshake or last write beat in cycle E:
  - `busy` = 0 from E+1.
  - The next request is accepted in E+1 at the earliest.
  - A request in cycle E itself is dropped and sets `err`.
- Read after write: a write in cycle E is visible to a read request made in E+1, whose data appears in E+2.
- `len` = 0 gives a single-beat burst.
- `len` = 2^MEM_LEN_BITS−1 gives 2^MEM_LEN_BITS beats.

## Configuration
- Macro: `MEM_RESPONDER_BOUNDS_CHECK_EN`.
- Defined:
  - A burst whose `word_index + len` exceeds 2^DEPTH_BITS−1 sets `err`.
  - Beats beyond the last word return 0 on reads and are discarded on writes.
  - `ptr` saturates at the last word and does not wrap.
  - Index bits above DEPTH_BITS that are non-zero also count as out of range.
- Undefined:
  - The index is truncated to DEPTH_BITS.
  - `ptr` wraps from the last word to word 0.
  - Range conditions never set `err`.

## Test plan
- **Reset defaults:** assert `reset` low mid-read burst -> outputs go to reset values immediately; after release, `busy` = 0 and `err` = 0.
- **Write then read:**
  - Write burst with addr 0x40, len 3, beats 0x11, 0x22, 0x33, 0x44.
  - Then read with addr 0x40, len 3, ready held high.
  - Expect `mem_rd_bits` = 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting 1 cycle after the request, then `busy` drops.
- **Backpressure:**
  - Read with len 1 at a word containing 0xA5; hold `mem_rd_ready` = 0 for 5 cycles.
  - Expect `mem_rd_valid` = 1 with 0xA5 stable for all 5 cycles; 2 handshakes then end the burst.
- **Collision:** issue a second request during a len-7 read -> read data sequence unchanged and `err` = 1 stays set until reset.
- **Wrap / bounds:**
  - Write addr = (1023 << 3), len 1, data 0xDEAD, 0xBEEF, with DEPTH_BITS = 10.
  - Without the macro: word 1023 = 0xDEAD and word 0 = 0xBEEF.
  - With the macro: word 1023 = 0xDEAD, word 0 unchanged, `err` = 1.
- **Single beat and back-to-back:**
  - Read with len 0, then a new read request in the cycle right after the handshake.
  - Expect one beat, then the second request accepted with `err` = 0.
